// File: rtl/display_scan_mux_pkg.sv
// Shared constants for the multiplexed BCD status display.
// Digit masks are sized for the widest supported display.
package display_pkg;

  localparam int NUM_DIGITS_DEF = 4;
  localparam int MAX_DIGITS = 8;

  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam logic [MAX_DIGITS-1:0] DIGIT_OFF = '1;

endpackage

// File: rtl/display_scan_mux_refresh_tick_gen.sv
// Digit-slot prescaler: emits one tick every REFRESH_DIV enabled cycles.
// The count freezes while enable is low.
module refresh_tick_gen #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0] tick_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (enable) begin
      if (tick_cnt == LAST) tick_cnt <= '0;
      else tick_cnt <= tick_cnt + DIV_W'(1);
    end
  end

  assign tick = enable && (tick_cnt == LAST);

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed BCD digit scanner feeding decod7seg.
// New digits are double-buffered and swapped only at frame wrap.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    lz_blank,
  input  logic                    load_req,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic                    load_ack,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_sel_n,
  output logic                    frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ALL_OFF =
    DIGIT_OFF[NUM_DIGITS-1:0];

  logic                  tick;
  logic                  boundary;
  logic                  take;
  logic [IDX_W-1:0]      idx;
  logic [DW-1:0]         staging;
  logic [DW-1:0]         shadow;
  logic                  pending;
  logic [DW-1:0]         upper;
  logic [3:0]            nibble;
  logic                  blank;
  logic [NUM_DIGITS-1:0] sel_on;

  refresh_tick_gen #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_tick (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .tick(tick)
  );

  assign boundary = tick && (idx == IDX_LAST);
  // A request in the boundary cycle counts as pending
  assign take = boundary && (pending || load_req);

  always_comb begin
    upper = shadow >> {idx, 2'b00};
    nibble = upper[3:0];
    blank = !enable || (nibble > BCD_MAX) ||
            (lz_blank && (idx != '0) && (upper == '0));
    sel_on = ALL_OFF;
    sel_on[idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      staging     <= '0;
      shadow      <= '0;
      pending     <= 1'b0;
      load_ack    <= 1'b0;
      frame_done  <= 1'b0;
      bcd_out     <= 4'd0;
      digit_sel_n <= ALL_OFF;
    end else begin
      if (tick) begin
        if (idx == IDX_LAST) idx <= '0;
        else idx <= idx + IDX_W'(1);
      end
      if (load_req) staging <= digits_in;
      if (take) begin
        shadow  <= load_req ? digits_in : staging;
        pending <= load_req;
      end else if (load_req) begin
        pending <= 1'b1;
      end
      load_ack    <= take;
      frame_done  <= boundary;
      bcd_out     <= nibble;
      digit_sel_n <= blank ? ALL_OFF : sel_on;
    end
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: directed scenarios plus random traffic,
// all outputs compared every cycle against a behavioural model.
module tb_display_scan_mux;

  localparam int ND = 4;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        lz_blank;
  logic        load_req;
  logic [15:0] digits_in;
  logic        load_ack;
  logic [3:0]  bcd_out;
  logic [3:0]  digit_sel_n;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  display_scan_mux #(
    .NUM_DIGITS(ND),
    .REFRESH_DIV(DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .lz_blank(lz_blank),
    .load_req(load_req),
    .digits_in(digits_in),
    .load_ack(load_ack),
    .bcd_out(bcd_out),
    .digit_sel_n(digit_sel_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: position counter, slot index, display word
  int          m_cnt;
  int          m_idx;
  logic [15:0] m_shadow;
  logic [15:0] m_stage;
  bit          m_pend;
  logic [3:0]  e_bcd;
  logic [3:0]  e_sel;
  bit          e_ack;
  bit          e_fd;
  bit          mvalid = 0;
  logic [15:0] m_upper;
  logic [3:0]  m_hot;
  bit          m_tick;
  bit          m_bnd;
  bit          m_blank;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_cnt = 0; m_idx = 0; m_shadow = 0; m_stage = 0; m_pend = 0;
      e_bcd = 0; e_sel = 4'hF; e_ack = 0; e_fd = 0;
    end else begin
      m_upper = m_shadow >> (4 * m_idx);
      e_bcd = m_upper[3:0];
      m_blank = !enable || (e_bcd > 9) ||
                (lz_blank && m_idx > 0 && m_upper == 0);
      m_hot = 4'(1 << m_idx);
      e_sel = m_blank ? 4'hF : ~m_hot;
      m_tick = enable && (m_cnt == DIV - 1);
      m_bnd = m_tick && (m_idx == ND - 1);
      e_fd = m_bnd;
      e_ack = m_bnd && (m_pend || load_req);
      if (e_ack) begin
        m_shadow = load_req ? digits_in : m_stage;
        m_pend = load_req;
      end else begin
        m_pend = m_pend || load_req;
      end
      if (load_req) m_stage = digits_in;
      if (enable) m_cnt = (m_cnt + 1) % DIV;
      if (m_tick) m_idx = (m_idx + 1) % ND;
    end
    mvalid = 1;
  end

  initial forever begin
    @(negedge clk);
    if (mvalid) begin
      check("m_bcd", bcd_out, e_bcd);
      check("m_sel", digit_sel_n, e_sel);
      check("m_ack", load_ack, e_ack);
      check("m_fd", frame_done, e_fd);
    end
  end

  task automatic wait_sig(input bit fd, input int maxc, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(fd ? frame_done : load_ack) && n < maxc);
    check(nm, fd ? frame_done : load_ack, 1);
  endtask

  // Call right after a frame wrap is seen; eb/es hold digit 0 in [3:0]
  task automatic show_frame(input logic [15:0] eb, input logic [15:0] es,
                            input string nm);
    for (int i = 0; i < ND; i++) begin
      repeat (i == 0 ? 1 : DIV) @(negedge clk);
      check($sformatf("%s_bcd%0d", nm, i), bcd_out, eb[4*i +: 4]);
      check($sformatf("%s_sel%0d", nm, i), digit_sel_n, es[4*i +: 4]);
    end
  endtask

  task automatic pulse(input logic [15:0] d);
    load_req = 1;
    digits_in = d;
    @(negedge clk);
    load_req = 0;
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] d;
    for (int i = 0; i < ND; i++)
      d[4*i +: 4] = ($urandom_range(0, 3) == 0) ? 4'd0
                                                : 4'($urandom_range(0, 11));
    return d;
  endfunction

  int n;

  initial begin
    rst = 1; enable = 1; lz_blank = 1; load_req = 0; digits_in = 0;
    repeat (3) @(negedge clk);
    check("rst_sel", digit_sel_n, 4'hF);
    check("rst_bcd", bcd_out, 0);
    check("rst_ack", load_ack, 0);
    rst = 0;
    @(negedge clk);
    check("first_d0_sel", digit_sel_n, 4'b1110);
    check("first_d0_bcd", bcd_out, 0);
    repeat (DIV) @(negedge clk);
    check("first_d1_dark", digit_sel_n, 4'hF);

    pulse(16'h1234);
    wait_sig(0, 40, "t2_ack");
    show_frame(16'h1234, 16'h7BDE, "t2");

    wait_sig(1, 40, "t3_fd");
    pulse(16'h1111);
    @(negedge clk);
    pulse(16'h0042);
    n = 0;
    repeat (18) begin
      @(negedge clk);
      n += int'(load_ack);
    end
    check("t3_acks", n, 1);
    wait_sig(1, 40, "t3_fd2");
    show_frame(16'h0042, 16'hFFDE, "t3");

    pulse(16'h00A5);
    wait_sig(0, 40, "t4_ack");
    show_frame(16'h00A5, 16'hFFFE, "t4");

    pulse(16'h1234);
    wait_sig(0, 40, "t5_ack");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (digit_sel_n != 4'b1011 && n < 40);
    check("t5_d2", digit_sel_n, 4'b1011);
    @(negedge clk);
    enable = 0;
    repeat (10) begin
      @(negedge clk);
      check("t5_dark", digit_sel_n, 4'hF);
    end
    enable = 1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (digit_sel_n == 4'b1011) n++;
      else break;
    end
    check("t5_resume_len", n, 2);

    wait_sig(1, 40, "t6_fd");
    repeat (2) @(negedge clk);
    pulse(16'h5678);
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("t6_d0_sel", digit_sel_n, 4'b1110);
    check("t6_d0_bcd", bcd_out, 0);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      n += int'(load_ack);
    end
    check("t6_no_ack", n, 0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 499) == 0);
      enable = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 49) == 0) lz_blank = ~lz_blank;
      load_req = ($urandom_range(0, 11) == 0);
      digits_in = rand_digits();
    end
    rst = 0;
    load_req = 0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
